// File: rtl/wb_data_bridge_pkg.sv
// Shared types and constants for the core-to-Wishbone data bridge.
package wb_data_bridge_pkg;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_BUSY = 2'd1,
    WB_HOLD = 2'd2
  } wb_state_e;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;

  localparam logic [31:0] WbBusErrData = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_data_bridge_if.sv
// Wishbone B4 classic bus bundle between the data bridge (master) and a slave.
interface wb_data_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_W-1:0]     wb_adr_o;
  logic [DATA_W/8-1:0]   wb_sel_o;
  logic [DATA_W-1:0]     wb_dat_o;
  logic [DATA_W-1:0]     wb_dat_i;
  logic                  wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Wait-state counter for the bridge's bus-timeout abort (used only with WB_TIMEOUT_EN).
module wb_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Saturates at LIMIT so a stuck hit cannot wrap back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !hit)
      cnt <= cnt + CW'(1);
  end

  assign hit = (cnt == CW'(LIMIT));

endmodule

// File: rtl/wb_data_bridge.sv
// Core data-RAM port to Wishbone B4 classic master with stall request and read hold.
// Optional bus-timeout abort enabled by defining WB_TIMEOUT_EN.
module wb_data_bridge
  import wb_data_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = WB_ADDR_W,
  parameter int unsigned DATA_W      = WB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_ce_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [DATA_W/8-1:0]  cpu_sel_i,
  input  logic [DATA_W-1:0]    cpu_data_i,
  output logic [DATA_W-1:0]    cpu_data_o,
  output logic                 stallreq_o,
  input  logic                 stall_i,
  input  logic                 flush_i,
  wb_data_bridge_if.master     wb,
  output logic                 bus_err_o
);

  localparam int unsigned       SEL_W    = DATA_W / 8;
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(WbBusErrData);

  if (TIMEOUT_CYC == 0 || (DATA_W % 8) != 0) begin : g_cfg_check
    $error("wb_data_bridge: TIMEOUT_CYC must be nonzero and DATA_W a multiple of 8");
  end

  wb_state_e state, state_nxt;

  logic                cyc_q, stb_q, we_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [SEL_W-1:0]    sel_q;
  logic [DATA_W-1:0]   dat_q;
  logic [DATA_W-1:0]   rd_buf;

  logic issue;
  logic finish;
  logic timeout;

`ifdef WB_TIMEOUT_EN
  logic tmo_hit;

  wb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .clr (issue),
    .inc (state == WB_BUSY && !wb.wb_ack_i),
    .hit (tmo_hit)
  );

  // Ack and flush both outrank the timeout in the same cycle.
  assign timeout = (state == WB_BUSY) && tmo_hit && !wb.wb_ack_i && !flush_i;
`else
  assign timeout = 1'b0;
`endif

  assign bus_err_o = timeout;

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    finish     = 1'b0;
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    unique case (state)
      WB_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          stallreq_o = 1'b1;
          issue      = 1'b1;
          state_nxt  = WB_BUSY;
        end
      end
      WB_BUSY: begin
        if (flush_i) begin
          state_nxt = WB_IDLE;
        end else if (wb.wb_ack_i) begin
          finish     = 1'b1;
          cpu_data_o = we_q ? '0 : wb.wb_dat_i;
          state_nxt  = stall_i ? WB_HOLD : WB_IDLE;
        end else if (timeout) begin
          finish     = 1'b1;
          cpu_data_o = ERR_DATA;
          state_nxt  = stall_i ? WB_HOLD : WB_IDLE;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      WB_HOLD: begin
        cpu_data_o = rd_buf;
        if (flush_i || !stall_i)
          state_nxt = WB_IDLE;
      end
      default: state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= WB_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q  <= 1'b0;
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      sel_q  <= '0;
      dat_q  <= '0;
      rd_buf <= '0;
    end else begin
      if (issue) begin
        cyc_q <= 1'b1;
        stb_q <= 1'b1;
        we_q  <= cpu_we_i;
        adr_q <= {cpu_addr_i[ADDR_W-1:2], 2'b00};
        sel_q <= cpu_sel_i;
        dat_q <= cpu_data_i;
      end else if (state_nxt != WB_BUSY) begin
        cyc_q <= 1'b0;
        stb_q <= 1'b0;
      end
      if (finish)
        rd_buf <= wb.wb_ack_i ? wb.wb_dat_i : ERR_DATA;
    end
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_dat_o = dat_q;

endmodule

// File: doc/wb_data_bridge.md
Name: wb_data_bridge

Overview:
Wishbone B4 classic master that sits directly downstream of the core's data-RAM port (ram_ce/we/sel/addr/data). It converts each single-cycle core memory access into a Wishbone bus cycle with arbitrary wait states. While the cycle is outstanding it raises a stall request to ctrl. It holds read data until the pipeline is released.

Parameters:
ADDR_W, 32, address width of core and bus
DATA_W, 32, data width; SEL width = DATA_W/8
TIMEOUT_CYC, 255, max BUSY cycles before abort (used only with feature)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
cpu_ce_i  in  1  core requests access this cycle
cpu_we_i  in  1  1=store, 0=load
cpu_addr_i  in  ADDR_W  byte address
cpu_sel_i  in  DATA_W/8  byte lanes
cpu_data_i  in  DATA_W  store data
cpu_data_o  out  DATA_W  load data to mem stage
stallreq_o  out  1  stall request to ctrl
stall_i  in  1  pipeline held by another requester (ctrl mem-stage stall bit)
flush_i  in  1  abort/discard current access
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_we_o  out  1  write enable
wb_adr_o  out  ADDR_W  address, low 2 bits forced 0
wb_sel_o  out  DATA_W/8  byte select
wb_dat_o  out  DATA_W  write data
wb_dat_i  in  DATA_W  read data
wb_ack_i  in  1  slave acknowledge
bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- States: IDLE, BUSY, HOLD. All wb_* outputs, rd_buf and state are registered.
- Reset (rst=0, asynchronous): state IDLE; all wb_* = 0; rd_buf = 0; bus_err_o = 0.
- Reset mid-cycle drops cyc/stb at once and discards the access.
- IDLE:
  - cpu_ce_i=1 and flush_i=0: stallreq_o=1 combinationally in the same cycle. Next edge loads cyc=stb=1, we, adr, sel, dat from cpu_* and moves to BUSY.
  - Otherwise: stallreq_o=0 and cpu_data_o=0.
- BUSY, wb_ack_i=0: stallreq_o=1; outputs hold stable (Wishbone rule).
- BUSY, wb_ack_i=1:
  - Same cycle: stallreq_o=0; cpu_data_o=wb_dat_i for loads, 0 for stores.
  - Next edge: cyc=stb=0 and rd_buf<=wb_dat_i. Go to HOLD if stall_i=1, else IDLE.
- HOLD: stallreq_o=0; cpu_data_o=rd_buf; return to IDLE when stall_i=0.
- Minimum latency: request in cycle N, cyc in N+1, earliest ack in N+1, so the pipeline is released after one extra cycle.
- flush_i=1 in any state (priority over ack):
  - Combinationally: stallreq_o=0.
  - Next edge: cyc=stb=0, state IDLE, no rd_buf update.
  - A request in the same cycle as flush is not issued.
- No back-to-back issue: a new request is accepted only from IDLE, so at least one cyc=0 cycle separates bus cycles.
- stall_i=1 in IDLE suppresses nothing. The request is issued, because the mem stage holds the request stable while stalled.

Optional Feature:
WB_TIMEOUT_EN
- With the macro: a counter clears on BUSY entry and increments each BUSY cycle without ack. When it reaches TIMEOUT_CYC:
  - Combinationally in that cycle: stallreq_o=0; cpu_data_o=32'hDEAD_BEEF; bus_err_o=1 for one cycle.
  - Next edge: cyc=stb=0, state goes to HOLD or IDLE as for ack, with rd_buf<=32'hDEAD_BEEF.
- An ack arriving in the same cycle as the timeout wins.
- Without the macro: no counter, BUSY waits indefinitely, bus_err_o tied 0.

Decomposition:
- Shared package/define file holds:
  - state encodings WB_IDLE/WB_BUSY/WB_HOLD
  - WbBusErrData = 32'hDEAD_BEEF
  - ADDR_W/DATA_W defaults
- One natural sub-module, wb_timeout_cnt (counter plus compare), instantiated only under WB_TIMEOUT_EN. Otherwise the block is a single module.

Test Plan:
- Reset then load: addr 0x0000_0104 (wb_adr_o=0x0000_0104), sel 4'b1111, slave acks after 3 cycles with 0x1234_5678 -> stallreq_o high 4 cycles, cpu_data_o=0x1234_5678 in the ack cycle, cyc drops next edge.
- Store: addr 0x0000_0200, sel 4'b0011, data 0xAABB_CCDD, zero-wait ack -> wb_we_o=1, wb_sel_o=0011, wb_dat_o=0xAABB_CCDD for exactly 1 cycle, stallreq_o released the cycle after the request.
- Ack while stall_i=1 with load data 0xCAFE_0001 -> HOLD entered, cpu_data_o stays 0xCAFE_0001 until stall_i falls, then IDLE with cpu_data_o=0.
- flush_i pulsed in the 2nd BUSY cycle of a load, slave never acks -> cyc/stb=0 next edge, stallreq_o=0 same cycle, rd_buf unchanged.
- Async reset asserted mid-BUSY -> all wb_* 0 immediately, state IDLE; a new load after release completes normally.
- WB_TIMEOUT_EN with TIMEOUT_CYC=4, no ack -> bus_err_o pulses once, cpu_data_o=0xDEAD_BEEF, cyc drops; same run with ack in the 4th cycle -> no bus_err_o.
